// File: rtl/wb_interconnect_1xn.sv
// Single-master, N-slave classic Wishbone shared-bus interconnect with
// prefix/mask decode, registered slave select, decode-error and watchdog timeout.
module wb_interconnect_1xn #(
    parameter int NUM_SLAVES = 3,
    parameter int ADR_W      = 32,
    parameter int DAT_W      = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          m_cyc_i,
    input  logic                          m_stb_i,
    input  logic                          m_we_i,
    input  logic [ADR_W-1:0]              m_adr_i,
    input  logic [DAT_W-1:0]              m_dat_i,
    input  logic [DAT_W/8-1:0]            m_sel_i,
    output logic [DAT_W-1:0]              m_dat_o,
    output logic                          m_ack_o,
    output logic                          m_err_o,
    input  logic [NUM_SLAVES*ADR_W-1:0]   slv_adr_prefix,
    input  logic [NUM_SLAVES*ADR_W-1:0]   slv_adr_mask,
    output logic [NUM_SLAVES-1:0]         s_cyc_o,
    output logic [NUM_SLAVES-1:0]         s_stb_o,
    output logic                          s_we_o,
    output logic [ADR_W-1:0]              s_adr_o,
    output logic [DAT_W-1:0]              s_dat_o,
    output logic [DAT_W/8-1:0]            s_sel_o,
    input  logic [NUM_SLAVES*DAT_W-1:0]   s_dat_i,
    input  logic [NUM_SLAVES-1:0]         s_ack_i,
    input  logic [NUM_SLAVES-1:0]         s_err_i,
    output logic                          decerr_o,
    output logic                          timeout_o
);

    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;

    logic [1:0]            r_state;
    logic [SEL_W-1:0]      r_sel;
    logic [TMR_W-1:0]      r_timer;
    logic                  r_tmo;

    logic [NUM_SLAVES-1:0] w_hit;
    logic                  w_any;
    logic [SEL_W-1:0]      w_win;
    logic [NUM_SLAVES-1:0] w_sel_onehot;
    logic                  w_sel_ack;
    logic                  w_sel_err;
    logic [DAT_W-1:0]      w_sel_dat;
    logic                  w_busy;
    logic                  w_err_st;

    // A prefix bit outside its mask leaves a residue after the XOR, so that slave never hits.
    always_comb begin
        w_hit = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            w_hit[k] = ((m_adr_i & slv_adr_mask[k*ADR_W +: ADR_W])
                        ^ slv_adr_prefix[k*ADR_W +: ADR_W]) == '0;
        end
    end

    // Scan downward so the lowest-index hit is written last and wins.
    always_comb begin
        w_win = '0;
        for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                w_win = SEL_W'(k);
            end
        end
    end

    assign w_any = |w_hit;

    always_comb begin
        w_sel_onehot = '0;
        w_sel_ack    = 1'b0;
        w_sel_err    = 1'b0;
        w_sel_dat    = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (r_sel == SEL_W'(k)) begin
                w_sel_onehot[k] = 1'b1;
                w_sel_ack       = s_ack_i[k];
                w_sel_err       = s_err_i[k];
                w_sel_dat       = s_dat_i[k*DAT_W +: DAT_W];
            end
        end
    end

    assign w_busy   = (r_state == ST_BUSY);
    assign w_err_st = (r_state == ST_ERR);

    assign s_cyc_o   = (w_busy && m_cyc_i) ? w_sel_onehot : '0;
    assign s_stb_o   = (w_busy && m_stb_i) ? w_sel_onehot : '0;
    assign m_ack_o   = w_busy & w_sel_ack;
    assign m_err_o   = (w_busy & w_sel_err) | w_err_st;
    assign m_dat_o   = w_busy ? w_sel_dat : '0;
    assign decerr_o  = w_err_st & ~r_tmo;
    assign timeout_o = w_err_st & r_tmo;

    assign s_we_o  = m_we_i;
    assign s_adr_o = m_adr_i;
    assign s_dat_o = m_dat_i;
    assign s_sel_o = m_sel_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_timer <= '0;
            r_tmo   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (m_cyc_i && m_stb_i) begin
                        if (w_any) begin
                            r_sel   <= w_win;
                            r_timer <= '0;
                            r_state <= ST_BUSY;
                        end else begin
                            r_tmo   <= 1'b0;
                            r_state <= ST_ERR;
                        end
                    end
                end
                ST_BUSY: begin
                    // A slave response on the watchdog's last cycle takes priority over the timeout.
                    if (w_sel_ack || w_sel_err) begin
                        r_state <= ST_IDLE;
                    end else if (!m_cyc_i) begin
                        r_state <= ST_IDLE;
                    end else if ((TIMEOUT != 0) && (r_timer == TMR_LAST)) begin
                        r_tmo   <= 1'b1;
                        r_state <= ST_ERR;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                ST_ERR: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_interconnect_1xn.sv
// Self-checking bench for wb_interconnect_1xn: directed scenarios plus randomized
// transactions compared against an address-map / transaction-level reference model.
module tb_wb_interconnect_1xn;

    localparam int NS  = 3;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              m_cyc_i, m_stb_i, m_we_i;
    logic [AW-1:0]     m_adr_i;
    logic [DW-1:0]     m_dat_i;
    logic [DW/8-1:0]   m_sel_i;
    logic [DW-1:0]     m_dat_o;
    logic              m_ack_o, m_err_o;
    logic [NS*AW-1:0]  slv_adr_prefix, slv_adr_mask;
    logic [NS-1:0]     s_cyc_o, s_stb_o;
    logic              s_we_o;
    logic [AW-1:0]     s_adr_o;
    logic [DW-1:0]     s_dat_o;
    logic [DW/8-1:0]   s_sel_o;
    logic [NS*DW-1:0]  s_dat_i;
    logic [NS-1:0]     s_ack_i, s_err_i;
    logic              decerr_o, timeout_o;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    logic [31:0] pm_pref [NS];
    logic [31:0] pm_mask [NS];

    wb_interconnect_1xn #(.NUM_SLAVES(NS), .ADR_W(AW), .DAT_W(DW), .TIMEOUT(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_adr_i(m_adr_i),
        .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_dat_o(m_dat_o), .m_ack_o(m_ack_o),
        .m_err_o(m_err_o), .slv_adr_prefix(slv_adr_prefix), .slv_adr_mask(slv_adr_mask),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
        .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .s_err_i(s_err_i), .decerr_o(decerr_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_map(input int k, input logic [31:0] p, input logic [31:0] m);
        pm_pref[k] = p;
        pm_mask[k] = m;
        slv_adr_prefix[k*AW +: AW] = p;
        slv_adr_mask[k*AW +: AW]   = m;
    endtask

    // Address map rule: slave k owns every address whose masked bits equal its prefix; first owner wins.
    function automatic int ref_decode(input logic [31:0] a);
        for (int k = 0; k < NS; k++) begin
            if ((a & pm_mask[k]) == pm_pref[k]) return k;
        end
        return -1;
    endfunction

    // One master transaction; the selected slave responds on busy cycle wt (never if wt >= TMO).
    task automatic do_txn(input logic [31:0] a, input logic we, input logic [31:0] d,
                          input logic [3:0] be, input int wt, input bit use_err,
                          input logic [31:0] rdv);
        int           exp_k;
        logic [95:0]  rd;
        bit           resp;
        exp_k = ref_decode(a);
        m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = we;
        m_adr_i = a; m_dat_i = d; m_sel_i = be;
        s_ack_i = '0; s_err_i = '0;
        #1;
        chk("idle_cyc", s_cyc_o, 0);
        chk("bcast_adr", s_adr_o, a);
        chk("bcast_dat", s_dat_o, d);
        chk("bcast_we", s_we_o, we);
        chk("bcast_sel", s_sel_o, be);
        tick;
        if (exp_k < 0) begin
            chk("decerr_merr", m_err_o, 1);
            chk("decerr_pulse", decerr_o, 1);
            chk("decerr_tmo", timeout_o, 0);
            chk("decerr_cyc", s_cyc_o, 0);
            chk("decerr_ack", m_ack_o, 0);
            m_cyc_i = 1'b0; m_stb_i = 1'b0;
            tick;
            chk("decerr_end_merr", m_err_o, 0);
            chk("decerr_end_pulse", decerr_o, 0);
            return;
        end
        for (int c = 0; c < 64; c++) begin
            resp = (c == wt);
            rd = {$urandom, $urandom, $urandom};
            if (resp) rd[exp_k*32 +: 32] = rdv;
            s_dat_i = rd;
            s_ack_i = 3'($urandom) & ~(3'b001 << exp_k);
            s_err_i = 3'($urandom) & ~(3'b001 << exp_k);
            if (resp) begin
                if (use_err) s_err_i[exp_k] = 1'b1;
                else         s_ack_i[exp_k] = 1'b1;
            end
            #1;
            chk("busy_cyc", s_cyc_o, 3'b001 << exp_k);
            chk("busy_stb", s_stb_o, 3'b001 << exp_k);
            chk("busy_dat", m_dat_o, rd[exp_k*32 +: 32]);
            chk("busy_ack", m_ack_o, resp && !use_err);
            chk("busy_err", m_err_o, resp && use_err);
            if (resp) begin
                tick;
                m_cyc_i = 1'b0; m_stb_i = 1'b0; s_ack_i = '0; s_err_i = '0;
                #1;
                chk("post_cyc", s_cyc_o, 0);
                chk("post_ack", m_ack_o, 0);
                chk("post_err", m_err_o, 0);
                chk("post_dat", m_dat_o, 0);
                return;
            end
            if (c == TMO - 1) begin
                tick;
                s_ack_i = '0; s_err_i = '0;
                #1;
                chk("tmo_merr", m_err_o, 1);
                chk("tmo_pulse", timeout_o, 1);
                chk("tmo_decerr", decerr_o, 0);
                chk("tmo_cyc", s_cyc_o, 0);
                chk("tmo_ack", m_ack_o, 0);
                m_cyc_i = 1'b0; m_stb_i = 1'b0;
                tick;
                chk("tmo_end_merr", m_err_o, 0);
                chk("tmo_end_pulse", timeout_o, 0);
                return;
            end
            tick;
        end
        chk("txn_budget", 1, 0);
    endtask

    task automatic default_map;
        set_map(0, 32'h0000_0000, 32'hFFFF_0000);
        set_map(1, 32'h1000_0000, 32'hFFFF_0000);
        set_map(2, 32'h8000_0000, 32'hF000_0000);
    endtask

    initial begin
        logic [31:0] a, p, m;
        int          k;

        rst_i = 1'b1;
        m_cyc_i = 0; m_stb_i = 0; m_we_i = 0; m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
        s_dat_i = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        s_ack_i = '1; s_err_i = '1;
        slv_adr_prefix = '0; slv_adr_mask = '0;
        default_map();
        #2;
        chk("rst_cyc", s_cyc_o, 0);
        chk("rst_stb", s_stb_o, 0);
        chk("rst_ack", m_ack_o, 0);
        chk("rst_err", m_err_o, 0);
        chk("rst_dat", m_dat_o, 0);
        chk("rst_decerr", decerr_o, 0);
        chk("rst_tmo", timeout_o, 0);
        tick; tick;
        rst_i = 1'b0;
        s_ack_i = '0; s_err_i = '0;

        // Read from slave 1 with a zero-wait ack
        do_txn(32'h1000_0040, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'hDEAD_BEEF);
        // Write to slave 2
        do_txn(32'h8123_4560, 1'b1, 32'hA5A5_A5A5, 4'hF, 0, 1'b0, 32'h0);
        // Unmapped address
        do_txn(32'h4000_0000, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'h0);
        // Watchdog on slave 1, then a normal transfer
        do_txn(32'h1000_0000, 1'b0, 32'h0, 4'hF, 100, 1'b0, 32'h0);
        do_txn(32'h1000_0004, 1'b0, 32'h0, 4'hF, 2, 1'b0, 32'h1234_5678);
        // Ack on the last watchdog cycle beats the timeout
        do_txn(32'h0000_0010, 1'b0, 32'h0, 4'h3, TMO - 1, 1'b0, 32'hCAFE_F00D);
        // Slave error forwarded
        do_txn(32'h8000_0020, 1'b1, 32'h5555_AAAA, 4'h1, 1, 1'b1, 32'h0);

        // Simultaneous ack and err from the selected slave
        m_cyc_i = 1; m_stb_i = 1; m_adr_i = 32'h1000_0100;
        tick;
        s_ack_i = 3'b010; s_err_i = 3'b010;
        #1;
        chk("both_ack", m_ack_o, 1);
        chk("both_err", m_err_o, 1);
        tick;
        m_cyc_i = 0; m_stb_i = 0; s_ack_i = '0; s_err_i = '0;
        #1;
        chk("both_idle", s_cyc_o, 0);

        // Back-to-back with stb held: one idle cycle between transfers
        m_cyc_i = 1; m_stb_i = 1; m_adr_i = 32'h0000_1234;
        tick;
        s_ack_i = 3'b001;
        #1;
        chk("b2b_ack1", m_ack_o, 1);
        tick;
        s_ack_i = '0;
        #1;
        chk("b2b_gap_cyc", s_cyc_o, 0);
        chk("b2b_gap_ack", m_ack_o, 0);
        tick;
        chk("b2b_second_cyc", s_cyc_o, 3'b001);
        s_ack_i = 3'b001;
        #1;
        chk("b2b_ack2", m_ack_o, 1);
        tick;
        m_cyc_i = 0; m_stb_i = 0; s_ack_i = '0;
        #1;

        // Master abort returns to idle without a response
        m_cyc_i = 1; m_stb_i = 1; m_adr_i = 32'h8000_0010;
        tick;
        chk("abort_busy", s_cyc_o, 3'b100);
        m_cyc_i = 0; m_stb_i = 0;
        #1;
        chk("abort_cyc_follow", s_cyc_o, 0);
        tick;
        chk("abort_no_err", m_err_o, 0);
        m_cyc_i = 1; m_stb_i = 1;
        #1;
        chk("abort_idle", s_cyc_o, 0);
        tick;
        chk("abort_redecode", s_cyc_o, 3'b100);
        s_ack_i = 3'b100;
        tick;
        m_cyc_i = 0; m_stb_i = 0; s_ack_i = '0;
        #1;

        // Asynchronous reset during a busy cycle
        m_cyc_i = 1; m_stb_i = 1; m_adr_i = 32'h8000_0040;
        tick;
        chk("rstmid_busy", s_cyc_o, 3'b100);
        s_dat_i = {32'hFFFF_FFFF, 32'hEEEE_EEEE, 32'hDDDD_DDDD};
        s_ack_i = 3'b100; s_err_i = 3'b100;
        #1 rst_i = 1'b1;
        #1;
        chk("rstmid_cyc", s_cyc_o, 0);
        chk("rstmid_stb", s_stb_o, 0);
        chk("rstmid_ack", m_ack_o, 0);
        chk("rstmid_err", m_err_o, 0);
        chk("rstmid_dat", m_dat_o, 0);
        tick;
        rst_i = 1'b0; s_ack_i = '0; s_err_i = '0;
        #1;
        chk("rstmid_idle", s_cyc_o, 0);
        m_cyc_i = 0; m_stb_i = 0;
        tick;

        // Overlapping maps: lowest index wins
        set_map(0, 32'h8000_0000, 32'hF000_0000);
        set_map(2, 32'h8000_0000, 32'hF000_0000);
        do_txn(32'h8000_0000, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'h0BAD_F00D);
        default_map();

        // Random traffic on the default map
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0:       a = {16'h0000, 16'($urandom)};
                1:       a = {16'h1000, 16'($urandom)};
                2:       a = {4'h8, 28'($urandom)};
                3:       a = {16'h4000, 16'($urandom)};
                default: a = $urandom;
            endcase
            do_txn(a, 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, 19),
                   $urandom_range(0, 5) == 0, $urandom);
        end

        // Random traffic on random maps, some with prefix bits outside the mask
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < NS; j++) begin
                m = {4'hF, 28'($urandom)} & {4'hF, 28'($urandom)};
                p = $urandom & m;
                if ($urandom_range(0, 4) == 0) p = p | (~m & (32'h1 << $urandom_range(0, 27)));
                set_map(j, p, m);
            end
            for (int i = 0; i < 10; i++) begin
                k = $urandom_range(0, NS - 1);
                if ($urandom_range(0, 3) == 0) a = $urandom;
                else a = pm_pref[k] | ($urandom & ~pm_mask[k]);
                do_txn(a, 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, 19),
                       $urandom_range(0, 5) == 0, $urandom);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
